// File: rtl/en_pipe_pkg.sv
// Shared types and helpers for the enable-gated multi-channel register pipeline.
package en_pipe_pkg;

  typedef enum logic {
    IDLE_HOLD = 1'b0,
    IDLE_ZERO = 1'b1
  } idle_mode_e;

  // Callers zero-extend their valid vectors to 256 bits, which caps DEPTH at 256.
  function automatic int unsigned popcount(input logic [255:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/en_pipe_chan.sv
// One channel of en_pipe: DEPTH {data, vld} stages with enable, idle mode, flush
// and a registered occupancy count that tracks the stages on the same edge.
module en_pipe_chan
  import en_pipe_pkg::*;
#(
  parameter int         WIDTH     = 1,
  parameter int         DEPTH     = 1,
  parameter idle_mode_e IDLE_MODE = IDLE_HOLD,
  localparam int        CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [CW-1:0]    occ
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             vld;
  } stage_t;

  stage_t [DEPTH-1:0] stg;
  stage_t [DEPTH-1:0] stg_nxt;
  logic   [DEPTH-1:0] vld_nxt;
  logic   [CW-1:0]    occ_nxt;

  always_comb begin
    stg_nxt = stg;
    if (flush || (!en && IDLE_MODE == IDLE_ZERO)) begin
      stg_nxt = '0;
    end else if (en) begin
      stg_nxt[0] = {d, d_vld};
      for (int i = 1; i < DEPTH; i++) begin
        stg_nxt[i] = stg[i-1];
      end
    end
  end

  // Occupancy is derived from the next-state valids so it never lags the stages.
  always_comb begin
    vld_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_nxt[i] = stg_nxt[i].vld;
    end
  end

  assign occ_nxt = CW'(popcount(256'(vld_nxt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
      occ <= '0;
    end else begin
      stg <= stg_nxt;
      occ <= occ_nxt;
    end
  end

  assign q     = stg[DEPTH-1].data;
  assign q_vld = stg[DEPTH-1].vld;

endmodule

// File: rtl/en_pipe.sv
// Multi-channel enable-gated register pipeline: NCH independent en_pipe_chan
// instances wired onto packed per-channel buses.
module en_pipe
  import en_pipe_pkg::*;
#(
  parameter int         WIDTH     = 1,
  parameter int         DEPTH     = 1,
  parameter int         NCH       = 1,
  parameter idle_mode_e IDLE_MODE = IDLE_HOLD,
  localparam int        CW        = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH-1:0]            en,
  input  logic                      flush,
  input  logic [NCH-1:0][WIDTH-1:0] d,
  input  logic [NCH-1:0]            d_vld,
  output logic [NCH-1:0][WIDTH-1:0] q,
  output logic [NCH-1:0]            q_vld,
  output logic [NCH-1:0][CW-1:0]    occ
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    en_pipe_chan #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .IDLE_MODE(IDLE_MODE)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (en[c]),
      .flush(flush),
      .d    (d[c]),
      .d_vld(d_vld[c]),
      .q    (q[c]),
      .q_vld(q_vld[c]),
      .occ  (occ[c])
    );
  end

endmodule
